// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: datapath widths, the x0 constant, the writeback
// request record used by execute/load units, and writeback port identifiers.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_LSU = 1'b1
  } wb_port_e;

  function automatic logic wb_writes_rf(input logic [REG_AW-1:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way writeback grant logic. Build with REGFILE_WB_RR_EN defined for
// round-robin on conflicts; otherwise port 0 (ALU) has fixed priority.
module wb_rr_arbiter
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  wb_port_e r_ptr;

  always_comb begin
    o_gnt = '0;
    if (!rst) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (r_ptr == PORT_ALU) ? 2'b01 : 2'b10;
        default: o_gnt = '0;
      endcase
    end
  end

  // The pointer only moves on contested grants; a fixed-priority build pins it
  // to the ALU port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= PORT_ALU;
    end else begin
`ifdef REGFILE_WB_RR_EN
      if (i_req == 2'b11)
        r_ptr <= (r_ptr == PORT_ALU) ? PORT_LSU : PORT_ALU;
`else
      r_ptr <= PORT_ALU;
`endif
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register_file write port between ALU and load writeback, with a
// one-entry commit stage and read-port forwarding. Arbitration policy is
// selected by REGFILE_WB_RR_EN (see wb_rr_arbiter).
module regfile_wb_arbiter #(
  parameter int unsigned XLEN   = riscv_pkg::XLEN,
  parameter int unsigned REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_valid,
  input  logic [REG_AW-1:0] wb0_rd,
  input  logic [XLEN-1:0]   wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [REG_AW-1:0] wb1_rd,
  input  logic [XLEN-1:0]   wb1_data,
  output logic              wb1_ready,
  output logic              rf_write_enable,
  output logic [REG_AW-1:0] rf_write_reg,
  output logic [XLEN-1:0]   rf_write_data,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [XLEN-1:0]   fwd_data1,
  output logic [XLEN-1:0]   fwd_data2
);
  import riscv_pkg::*;

  logic [1:0]        w_gnt;
  logic              w_acc;
  logic [REG_AW-1:0] w_rd;
  logic [XLEN-1:0]   w_data;

  logic              r_we;
  logic [REG_AW-1:0] r_reg;
  logic [XLEN-1:0]   r_data;

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({wb1_valid, wb0_valid}),
    .o_gnt (w_gnt)
  );

  assign wb0_ready = w_gnt[0];
  assign wb1_ready = w_gnt[1];
  assign w_acc     = |w_gnt;
  assign w_rd      = w_gnt[1] ? wb1_rd   : wb0_rd;
  assign w_data    = w_gnt[1] ? wb1_data : wb0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_reg  <= '0;
      r_data <= '0;
    end else if (w_acc) begin
      r_we   <= (w_rd != '0);
      r_reg  <= w_rd;
      r_data <= w_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  // Enable is masked by rst so a commit pending when reset arrives never
  // reaches register_file at the reset edge.
  assign rf_write_enable = r_we & ~rst;
  assign rf_write_reg    = r_reg;
  assign rf_write_data   = r_data;

  always_comb begin
    fwd_hit1  = rf_write_enable && (rd_addr1 == r_reg) && (rd_addr1 != '0);
    fwd_hit2  = rf_write_enable && (rd_addr2 == r_reg) && (rd_addr2 != '0);
    fwd_data1 = fwd_hit1 ? r_data : '0;
    fwd_data2 = fwd_hit2 ? r_data : '0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter; includes a behavioural
// register_file fed from the DUT write port.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [4:0]  wb0_rd, wb1_rd, rd_addr1, rd_addr2, rf_write_reg;
  logic [31:0] wb0_data, wb1_data, rf_write_data, fwd_data1, fwd_data2;
  logic        rf_write_enable, fwd_hit1, fwd_hit2;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] rf [32];

  regfile_wb_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .wb0_valid       (wb0_valid),
    .wb0_rd          (wb0_rd),
    .wb0_data        (wb0_data),
    .wb0_ready       (wb0_ready),
    .wb1_valid       (wb1_valid),
    .wb1_rd          (wb1_rd),
    .wb1_data        (wb1_data),
    .wb1_ready       (wb1_ready),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data),
    .rd_addr1        (rd_addr1),
    .rd_addr2        (rd_addr2),
    .fwd_hit1        (fwd_hit1),
    .fwd_hit2        (fwd_hit2),
    .fwd_data1       (fwd_data1),
    .fwd_data2       (fwd_data2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_write_enable && rf_write_reg != 5'd0)
      rf[rf_write_reg] <= rf_write_data;
  end

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  typedef struct {
    logic        v0; logic [4:0] rd0; logic [31:0] d0;
    logic        v1; logic [4:0] rd1; logic [31:0] d1;
    logic [4:0]  a1; logic [4:0] a2;
    logic        r0; logic       r1;
    logic        we; logic [4:0] wreg; logic [31:0] wdata;
    logic        h1; logic       h2; logic [31:0] fd1; logic [31:0] fd2;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
    rd_addr1 = 0; rd_addr2 = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;

    vecs[0] = '{1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0,
                1'b1, 1'b0, 1'b1, 5'd1, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0,
                1'b0, 1'b0, 1'b0, 5'd1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 5'd2, 32'h12345678, 1'b1, 5'd3, 32'hCAFEF00D, 5'd2, 5'd3,
                1'b1, 1'b0, 1'b1, 5'd2, 32'h12345678, 1'b1, 1'b0, 32'h12345678, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hCAFEF00D, 5'd2, 5'd3,
                1'b0, 1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3,
                1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
                1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0};

    // Reset with both requesters active
    idle_inputs();
    rst = 1;
    wb0_valid = 1; wb0_rd = 5'd4; wb0_data = 32'h44;
    wb1_valid = 1; wb1_rd = 5'd6; wb1_data = 32'h66;
    rd_addr1 = 5'd4; rd_addr2 = 5'd6;
    #1;
    chk("rst_ready0", {31'd0, wb0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, wb1_ready}, 32'd0);
    tick();
    chk("rst_we",    {31'd0, rf_write_enable}, 32'd0);
    chk("rst_reg",   {27'd0, rf_write_reg}, 32'd0);
    chk("rst_data",  rf_write_data, 32'd0);
    chk("rst_hit",   {30'd0, fwd_hit1, fwd_hit2}, 32'd0);
    chk("rst_fdata", fwd_data1 | fwd_data2, 32'd0);
    rst = 0;
    idle_inputs();

    // Table-driven: single write, conflict, x0 write
    for (int i = 0; i < 6; i++) begin
      wb0_valid = vecs[i].v0; wb0_rd = vecs[i].rd0; wb0_data = vecs[i].d0;
      wb1_valid = vecs[i].v1; wb1_rd = vecs[i].rd1; wb1_data = vecs[i].d1;
      rd_addr1 = vecs[i].a1; rd_addr2 = vecs[i].a2;
      #1;
      chk($sformatf("v%0d_ready0", i), {31'd0, wb0_ready}, {31'd0, vecs[i].r0});
      chk($sformatf("v%0d_ready1", i), {31'd0, wb1_ready}, {31'd0, vecs[i].r1});
      tick();
      chk($sformatf("v%0d_we", i),    {31'd0, rf_write_enable}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d_reg", i),   {27'd0, rf_write_reg}, {27'd0, vecs[i].wreg});
      chk($sformatf("v%0d_data", i),  rf_write_data, vecs[i].wdata);
      chk($sformatf("v%0d_hit1", i),  {31'd0, fwd_hit1}, {31'd0, vecs[i].h1});
      chk($sformatf("v%0d_hit2", i),  {31'd0, fwd_hit2}, {31'd0, vecs[i].h2});
      chk($sformatf("v%0d_fdata1", i), fwd_data1, vecs[i].fd1);
      chk($sformatf("v%0d_fdata2", i), fwd_data2, vecs[i].fd2);
    end
    idle_inputs();
    chk("rf_x1", rf_read(5'd1), 32'hDEADBEEF);
    chk("rf_x2", rf_read(5'd2), 32'h12345678);
    chk("rf_x3", rf_read(5'd3), 32'hCAFEF00D);
    chk("rf_x0", rf_read(5'd0), 32'h0);

    // Same rd on both ports: loser's data must land last
    do_reset();
    wb0_valid = 1; wb0_rd = 5'd5; wb0_data = 32'h1;
    wb1_valid = 1; wb1_rd = 5'd5; wb1_data = 32'h2;
    #1;
    chk("same_ready0", {31'd0, wb0_ready}, 32'd1);
    chk("same_ready1", {31'd0, wb1_ready}, 32'd0);
    tick();
    chk("same_first_data", rf_write_data, 32'h1);
    wb0_valid = 0;
    #1;
    chk("same_ready1_b", {31'd0, wb1_ready}, 32'd1);
    tick();
    chk("same_second_reg",  {27'd0, rf_write_reg}, 32'd5);
    chk("same_second_data", rf_write_data, 32'h2);
    idle_inputs();
    tick();
    chk("same_rf_x5", rf_read(5'd5), 32'h2);

    // Sustained contention for six cycles
    do_reset();
    wb0_valid = 1; wb0_rd = 5'd10; wb0_data = 32'hA0;
    wb1_valid = 1; wb1_rd = 5'd11; wb1_data = 32'hB1;
    for (int c = 0; c < 6; c++) begin
      logic [31:0] exp_g;
`ifdef REGFILE_WB_RR_EN
      exp_g = c % 2;
`else
      exp_g = 0;
`endif
      #1;
      chk($sformatf("cont%0d_onegrant", c), {31'd0, wb0_ready ^ wb1_ready}, 32'd1);
      chk($sformatf("cont%0d_port", c), {31'd0, wb1_ready}, exp_g);
      tick();
    end
    idle_inputs();

    // Reset arriving while a commit is pending
    do_reset();
    wb0_valid = 1; wb0_rd = 5'd7; wb0_data = 32'h77;
    #1;
    chk("rmid_accept", {31'd0, wb0_ready}, 32'd1);
    tick();
    rst = 1;
    wb0_rd = 5'd8; wb0_data = 32'h88; rd_addr1 = 5'd7;
    #1;
    chk("rmid_ready_in_rst", {31'd0, wb0_ready}, 32'd0);
    chk("rmid_we_masked",    {31'd0, rf_write_enable}, 32'd0);
    chk("rmid_hit_masked",   {31'd0, fwd_hit1}, 32'd0);
    tick();
    chk("rmid_reg_clr",  {27'd0, rf_write_reg}, 32'd0);
    chk("rmid_data_clr", rf_write_data, 32'd0);
    chk("rmid_no_write", rf_read(5'd7), 32'd0);
    tick();
    chk("rmid_ready_hold", {31'd0, wb0_ready}, 32'd0);
    chk("rmid_no_write2",  rf_read(5'd7), 32'd0);
    rst = 0;
    #1;
    chk("rmid_ready_after", {31'd0, wb0_ready}, 32'd1);
    tick();
    chk("rmid_post_we",  {31'd0, rf_write_enable}, 32'd1);
    chk("rmid_post_reg", {27'd0, rf_write_reg}, 32'd8);
    idle_inputs();
    tick();
    chk("rmid_rf_x8", rf_read(5'd8), 32'h88);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
